// File: rtl/wiscf15_pkg.sv
// Shared WISC-F15 definitions: ALU opcodes, branch condition codes, the flag
// bundle, and the per-opcode flag-update mask used by both the ALU and the
// EX/MEM stage.
package wiscf15_pkg;

  localparam logic [3:0] OpAdd    = 4'b0000;
  localparam logic [3:0] OpPaddsb = 4'b0001;
  localparam logic [3:0] OpSub    = 4'b0010;
  localparam logic [3:0] OpNand   = 4'b0011;
  localparam logic [3:0] OpXor    = 4'b0100;
  localparam logic [3:0] OpSll    = 4'b0101;
  localparam logic [3:0] OpSrl    = 4'b0110;
  localparam logic [3:0] OpSra    = 4'b0111;
  localparam logic [3:0] OpLw     = 4'b1000;
  localparam logic [3:0] OpSw     = 4'b1001;
  localparam logic [3:0] OpHlt    = 4'b1111;

  typedef enum logic [2:0] {
    CccNe     = 3'b000,
    CccEq     = 3'b001,
    CccGt     = 3'b010,
    CccLt     = 3'b011,
    CccGe     = 3'b100,
    CccLe     = 3'b101,
    CccOv     = 3'b110,
    CccAlways = 3'b111
  } ccc_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  // Which architectural flags an opcode writes when it retires from EX.
  function automatic flags_t flag_mask(logic [3:0] func);
    flags_t m;
    m = '0;
    case (func)
      OpAdd, OpSub:                       m = 3'b111;
      OpNand, OpXor, OpSll, OpSrl, OpSra: m.z = 1'b1;
      default:                            m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wiscf15_ex_mem_stage_if.sv
// EX/MEM stage bus: EX-side inputs, stall/flush control, branch condition
// query and the registered MEM-side outputs.
//   master : upstream / environment (drives ex_*, stall, flush, br_ccc)
//   slave  : the EX/MEM stage itself
interface wiscf15_ex_mem_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
);
  logic          ex_valid;
  logic [3:0]    ex_func;
  logic [DW-1:0] ex_result;
  logic          ex_v;
  logic          ex_z;
  logic          ex_n;
  logic [DW-1:0] ex_st_data;
  logic [RW-1:0] ex_dst;
  logic          ex_rf_we;
  logic          stall;
  logic          flush;
  logic [2:0]    br_ccc;

  logic          br_taken;
  logic          flag_z;
  logic          flag_v;
  logic          flag_n;
  logic          mem_valid;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [RW-1:0] mem_dst;
  logic          mem_rf_we;
  logic          halt;

  modport master (
    output ex_valid, ex_func, ex_result, ex_v, ex_z, ex_n, ex_st_data, ex_dst, ex_rf_we,
    output stall, flush, br_ccc,
    input  br_taken, flag_z, flag_v, flag_n, mem_valid, mem_addr, mem_wdata,
    input  mem_re, mem_we, mem_dst, mem_rf_we, halt
  );

  modport slave (
    input  ex_valid, ex_func, ex_result, ex_v, ex_z, ex_n, ex_st_data, ex_dst, ex_rf_we,
    input  stall, flush, br_ccc,
    output br_taken, flag_z, flag_v, flag_n, mem_valid, mem_addr, mem_wdata,
    output mem_re, mem_we, mem_dst, mem_rf_we, halt
  );
endinterface

// File: rtl/wiscf15_flag_unit.sv
// Architectural Z/V/N register with per-opcode update mask, EX bypass and
// branch condition decode.
//   i_live     : EX instruction is real and not killed (valid & ~flush & ~halt)
//   i_stall    : hold the flag register
//   i_func     : EX opcode
//   i_ex_flags : raw ALU flags of the EX instruction
//   i_ccc      : condition code of the branch in decode
//   o_flags    : registered architectural flags
//   o_br_taken : condition met, evaluated on the bypassed flags
module wiscf15_flag_unit
  import wiscf15_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_live,
  input  logic       i_stall,
  input  logic [3:0] i_func,
  input  flags_t     i_ex_flags,
  input  logic [2:0] i_ccc,
  output flags_t     o_flags,
  output logic       o_br_taken
);

  flags_t r_flags;
  flags_t w_mask;
  flags_t w_eff;
  logic   w_br;

  assign w_mask = i_live ? flag_mask(i_func) : '0;

  // Bypass ignores stall: decode must see the result the EX op will commit.
  always_comb begin
    w_eff.z = w_mask.z ? i_ex_flags.z : r_flags.z;
    w_eff.v = w_mask.v ? i_ex_flags.v : r_flags.v;
    w_eff.n = w_mask.n ? i_ex_flags.n : r_flags.n;
  end

  // With a zero mask w_eff equals r_flags, so bubbles leave the flags alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (!i_stall) begin
      r_flags <= w_eff;
    end
  end

  always_comb begin
    w_br = 1'b0;
    unique case (ccc_e'(i_ccc))
      CccNe:     w_br = ~w_eff.z;
      CccEq:     w_br = w_eff.z;
      CccGt:     w_br = ~w_eff.z & ~w_eff.n;
      CccLt:     w_br = w_eff.n;
      CccGe:     w_br = w_eff.z | ~w_eff.n;
      CccLe:     w_br = w_eff.n | w_eff.z;
      CccOv:     w_br = w_eff.v;
      CccAlways: w_br = 1'b1;
      default:   w_br = 1'b0;
    endcase
  end

  assign o_flags    = r_flags;
  assign o_br_taken = w_br;

endmodule

// File: rtl/wiscf15_ex_mem_stage.sv
// WISC-F15 EX/MEM pipeline register. Captures the ALU result and control one
// cycle after EX, gates memory and register-file strobes with mem_valid,
// latches a sticky halt on HLT, and hosts the flag unit for branch decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of wiscf15_ex_mem_stage_if (EX inputs, stall,
//                flush, br_ccc in; mem_*, flags, br_taken, halt out)
module wiscf15_ex_mem_stage
  import wiscf15_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wiscf15_ex_mem_stage_if.slave  bus
);

  logic          r_valid;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [RW-1:0] r_dst;
  logic          r_is_lw;
  logic          r_is_sw;
  logic          r_rf_we;
  logic          r_halt;

  logic          w_live;
  logic          w_accept;
  logic          w_is_hlt;
  logic          w_is_sw;
  flags_t        w_ex_flags;
  flags_t        w_flags;

  assign w_live   = bus.ex_valid & ~bus.flush & ~r_halt;
  assign w_accept = w_live & ~bus.stall;
  assign w_is_hlt = (bus.ex_func == OpHlt);
  assign w_is_sw  = (bus.ex_func == OpSw);

  // Data fields track EX on bubbles too; only r_valid and the strobes matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_dst   <= '0;
      r_is_lw <= 1'b0;
      r_is_sw <= 1'b0;
      r_rf_we <= 1'b0;
      r_halt  <= 1'b0;
    end else if (!bus.stall) begin
      r_valid <= w_accept;
      r_addr  <= bus.ex_result;
      r_wdata <= bus.ex_st_data;
      r_dst   <= bus.ex_dst;
      r_is_lw <= (bus.ex_func == OpLw);
      r_is_sw <= w_is_sw;
      r_rf_we <= bus.ex_rf_we & ~w_is_sw & ~w_is_hlt;
      if (w_accept && w_is_hlt) begin
        r_halt <= 1'b1;
      end
    end
  end

  assign w_ex_flags = '{z: bus.ex_z, v: bus.ex_v, n: bus.ex_n};

  wiscf15_flag_unit u_flag_unit (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_live     (w_live),
    .i_stall    (bus.stall),
    .i_func     (bus.ex_func),
    .i_ex_flags (w_ex_flags),
    .i_ccc      (bus.br_ccc),
    .o_flags    (w_flags),
    .o_br_taken (bus.br_taken)
  );

  assign bus.flag_z    = w_flags.z;
  assign bus.flag_v    = w_flags.v;
  assign bus.flag_n    = w_flags.n;
  assign bus.mem_valid = r_valid;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_dst   = r_dst;
  assign bus.mem_re    = r_valid & r_is_lw;
  assign bus.mem_we    = r_valid & r_is_sw;
  assign bus.mem_rf_we = r_valid & r_rf_we;
  assign bus.halt      = r_halt;

endmodule

// File: tb/tb_wiscf15_ex_mem_stage.sv
`timescale 1ns/1ps
module tb_wiscf15_ex_mem_stage;

  localparam logic [3:0] ADD = 4'h0, PADDSB = 4'h1, SUB = 4'h2, NAND = 4'h3, XOR = 4'h4;
  localparam logic [3:0] SLL = 4'h5, SRL = 4'h6, SRA = 4'h7, LW = 4'h8, SW = 4'h9, HLT = 4'hF;

  typedef struct packed {
    logic        valid;
    logic        re;
    logic        we;
    logic        rf_we;
    logic        z;
    logic        v;
    logic        n;
    logic        halt;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [3:0]  dst;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t m;          // reference-model view of the stage after the next edge
  exp_t q[$];       // expected post-edge state, one entry per clocked cycle

  wiscf15_ex_mem_stage_if bus ();

  wiscf15_ex_mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic cond(input logic [2:0] c, input logic z, input logic v,
                                input logic n);
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic writes_all(input logic [3:0] f);
    return f == ADD || f == SUB;
  endfunction

  function automatic logic writes_z_only(input logic [3:0] f);
    return f == NAND || f == XOR || f == SLL || f == SRL || f == SRA;
  endfunction

  // Monitor: compare the DUT against the oldest expectation after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("mem_valid", 16'(bus.mem_valid), 16'(e.valid));
      check("mem_re", 16'(bus.mem_re), 16'(e.re));
      check("mem_we", 16'(bus.mem_we), 16'(e.we));
      check("mem_rf_we", 16'(bus.mem_rf_we), 16'(e.rf_we));
      check("flags_zvn", {13'd0, bus.flag_z, bus.flag_v, bus.flag_n}, {13'd0, e.z, e.v, e.n});
      check("halt", 16'(bus.halt), 16'(e.halt));
      if (e.valid) begin
        check("mem_addr", bus.mem_addr, e.addr);
        check("mem_wdata", bus.mem_wdata, e.wdata);
        check("mem_dst", 16'(bus.mem_dst), 16'(e.dst));
      end
    end
  end

  // One EX cycle: drive, check the combinational branch, advance the model.
  task automatic drive(input logic valid, input logic [3:0] func, input logic [15:0] res,
                       input logic v, input logic z, input logic n, input logic [15:0] st,
                       input logic [3:0] dst, input logic rfwe, input logic stall,
                       input logic flush, input logic [2:0] ccc);
    logic live, ez, ev, en;
    @(negedge clk);
    bus.ex_valid = valid; bus.ex_func = func; bus.ex_result = res;
    bus.ex_v = v; bus.ex_z = z; bus.ex_n = n; bus.ex_st_data = st;
    bus.ex_dst = dst; bus.ex_rf_we = rfwe; bus.stall = stall; bus.flush = flush;
    bus.br_ccc = ccc;
    #1;
    live = valid && !flush && !m.halt;
    ez = (live && (writes_all(func) || writes_z_only(func))) ? z : m.z;
    ev = (live && writes_all(func)) ? v : m.v;
    en = (live && writes_all(func)) ? n : m.n;
    check("br_taken", 16'(bus.br_taken), 16'(cond(ccc, ez, ev, en)));
    if (!stall) begin
      if (live) begin
        m.valid = 1'b1;
        m.addr  = res;
        m.wdata = st;
        m.dst   = dst;
        m.re    = (func == LW);
        m.we    = (func == SW);
        m.rf_we = rfwe && func != SW && func != HLT;
        m.z = ez; m.v = ev; m.n = en;
        if (func == HLT) m.halt = 1'b1;
      end else begin
        m.valid = 1'b0; m.re = 1'b0; m.we = 1'b0; m.rf_we = 1'b0;
      end
    end
    q.push_back(m);
  endtask

  task automatic idle(input logic [2:0] ccc);
    drive(1'b0, ADD, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, ccc);
  endtask

  // Mid-cycle reset: outputs must clear immediately, without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    bus.ex_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_mem_valid", 16'(bus.mem_valid), 16'h0);
    check("rst_halt", 16'(bus.halt), 16'h0);
    check("rst_flags", {13'd0, bus.flag_z, bus.flag_v, bus.flag_n}, 16'h0);
    check("rst_strobes", {13'd0, bus.mem_re, bus.mem_we, bus.mem_rf_we}, 16'h0);
    m = '0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m       = '0;
    rst_n   = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_func = ADD; bus.ex_result = '0; bus.ex_v = 1'b0;
    bus.ex_z = 1'b0; bus.ex_n = 1'b0; bus.ex_st_data = '0; bus.ex_dst = '0;
    bus.ex_rf_we = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.br_ccc = 3'd0;
    do_reset();

    // ADD with overflow; OV branch sees V through the bypass.
    drive(1, ADD, 16'h7FFF, 1, 0, 0, 16'h0, 4'd1, 1, 0, 0, 3'b110);
    idle(3'b110);
    // SUB sets Z, XOR touches only Z, PADDSB touches nothing.
    drive(1, SUB, 16'h0000, 0, 1, 0, 16'h0, 4'd2, 1, 0, 0, 3'b001);
    drive(1, XOR, 16'h1234, 1, 0, 0, 16'h0, 4'd3, 1, 0, 0, 3'b110);
    drive(1, PADDSB, 16'h0000, 0, 1, 1, 16'h0, 4'd4, 1, 0, 0, 3'b001);
    idle(3'b000);
    // LW held by a 3-cycle stall; the following ADD waits.
    drive(1, LW, 16'h0040, 0, 0, 0, 16'h0, 4'd3, 1, 0, 0, 3'b000);
    for (int i = 0; i < 3; i++) drive(1, ADD, 16'h1111, 0, 1, 1, 16'h0, 4'd5, 1, 1, 0, 3'b001);
    drive(1, ADD, 16'h1111, 0, 1, 1, 16'h0, 4'd5, 1, 0, 0, 3'b011);
    // SW flushed, then SW accepted.
    drive(1, SW, 16'h0010, 1, 0, 1, 16'hBEEF, 4'd6, 1, 0, 1, 3'b000);
    drive(1, SW, 16'h0010, 1, 0, 1, 16'hBEEF, 4'd6, 1, 0, 0, 3'b000);
    // Stalled HLT does not halt; flushed HLT is dropped; then HLT taken.
    drive(1, HLT, 16'h0, 0, 0, 0, 16'h0, 4'd7, 1, 1, 0, 3'b000);
    drive(1, HLT, 16'h0, 0, 0, 0, 16'h0, 4'd7, 1, 0, 1, 3'b000);
    drive(1, HLT, 16'h0, 0, 0, 0, 16'h0, 4'd7, 1, 0, 0, 3'b000);
    drive(1, ADD, 16'h2222, 1, 1, 1, 16'h0, 4'd8, 1, 0, 0, 3'b111);
    drive(1, ADD, 16'h2222, 1, 1, 1, 16'h0, 4'd8, 1, 0, 0, 3'b001);
    do_reset();

    // Branch table over all registered flag combinations.
    for (int f = 0; f < 8; f++) begin
      logic [2:0] fl;
      fl = 3'(f);
      drive(1, ADD, 16'h0, fl[1], fl[2], fl[0], 16'h0, 4'd0, 0, 0, 0, 3'b111);
      for (int c = 0; c < 8; c++) idle(3'(c));
    end

    // Randomized traffic; reset occasionally to escape halt.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] f;
      f = 4'($urandom_range(0, 15));
      if (f == HLT && ($urandom % 6) != 0) f = ADD;
      if (m.halt && ($urandom % 6) == 0) do_reset();
      drive(($urandom % 5) != 0, f, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            16'($urandom), 4'($urandom), 1'($urandom), ($urandom % 5) == 0,
            ($urandom % 8) == 0, 3'($urandom));
    end

    @(negedge clk);
    check("scoreboard_drained", 16'(q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
